// File: rtl/spi_frame_seq.sv
// Frame sequencer in front of the SPI master: divides clk into the master's 2x SCK
// enable, drives the byte handshake for a 4-byte frame and captures bytes 2/3.
module spi_frame_seq #(
  parameter int unsigned CLK_DIV     = 6,
  parameter logic [7:0]  ADDR        = 8'h08,
  parameter int unsigned SETUP_TICKS = 2,
  parameter int unsigned GAP_TICKS   = 4,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [7:0]  cmd_i,
  output logic        busy_o,
  output logic [15:0] data_o,
  output logic        done_o,
  output logic        err_o,
  output logic        ena_2clk_o,
  output logic        start_o,
  output logic        ack_o,
  output logic [7:0]  tx_o,
  input  logic        busy_i,
  input  logic [7:0]  rx_i,
  output logic        ssb_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_XFER,
    S_ACK,
    S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  tick_q, tick_d;
  logic [15:0] wdog_q, wdog_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  rx2_q, rx2_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        low_seen_q, low_seen_d;
  logic        busy_in_q;

  logic        ena;
  logic        busy_fall;
  logic        timeout;
  logic        in_frame;
  logic        in_xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      tick_q     <= '0;
      wdog_q     <= '0;
      idx_q      <= '0;
      cmd_q      <= '0;
      rx2_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      low_seen_q <= 1'b0;
      busy_in_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      wdog_q     <= wdog_d;
      idx_q      <= idx_d;
      cmd_q      <= cmd_d;
      rx2_q      <= rx2_d;
      data_q     <= data_d;
      err_q      <= err_d;
      done_q     <= done_d;
      low_seen_q <= low_seen_d;
      busy_in_q  <= busy_i;
    end
  end

  always_comb begin
    ena       = (div_q == 8'(CLK_DIV - 1));
    div_d     = ena ? '0 : div_q + 8'd1;
    busy_fall = busy_in_q & ~busy_i;
    timeout   = (wdog_q == 16'(TIMEOUT));

    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    cmd_d      = cmd_q;
    rx2_d      = rx2_q;
    data_d     = data_q;
    err_d      = err_q;
    done_d     = 1'b0;
    low_seen_d = 1'b0;
    start_o    = 1'b0;
    ack_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cmd_d   = cmd_i;
          err_d   = 1'b0;
          idx_d   = '0;
          tick_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (ena) begin
          if (tick_q == 8'(SETUP_TICKS - 1)) state_d = S_START;
          else                               tick_d  = tick_q + 8'd1;
        end
      end
      S_START: begin
        if (timeout) begin
          ack_o   = 1'b1;
          err_d   = 1'b1;
          tick_d  = '0;
          state_d = S_GAP;
        end else begin
          // busy_i only counts as a handshake once it has been seen low in this state
          low_seen_d = low_seen_q | ~busy_i;
          if (busy_i && low_seen_q) state_d = S_XFER;
          else                      start_o = 1'b1;
        end
      end
      S_XFER: begin
        if (timeout) begin
          ack_o   = 1'b1;
          err_d   = 1'b1;
          tick_d  = '0;
          state_d = S_GAP;
        end else if (busy_fall) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_o = 1'b1;
        if (idx_q == 2'd2) rx2_d = rx_i;
        if (idx_q == 2'd3) begin
          data_d  = {rx2_q, rx_i};
          done_d  = 1'b1;
          tick_d  = '0;
          state_d = S_GAP;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_START;
        end
      end
      S_GAP: begin
        // the first pulse only aligns to the divider phase, so ssb stays high
        // for at least GAP_TICKS full enable periods
        if (ena) begin
          if (tick_q == 8'(GAP_TICKS)) state_d = S_IDLE;
          else                         tick_d  = tick_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_xfer = (state_q == S_START) || (state_q == S_XFER);
    wdog_d  = (in_xfer && (state_d == state_q)) ? wdog_q + 16'd1 : '0;
  end

  always_comb begin
    in_frame = (state_q == S_START) || (state_q == S_XFER) || (state_q == S_ACK);
    tx_o     = '0;
    if (in_frame) begin
      case (idx_q)
        2'd0:    tx_o = ADDR;
        2'd1:    tx_o = cmd_q;
        default: tx_o = 8'h00;
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign ssb_o      = ~(in_frame || (state_q == S_SETUP));
  assign data_o     = data_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign ena_2clk_o = ena;

endmodule

// File: tb/tb_spi_frame_seq.sv
// Directed bench for spi_frame_seq with a behavioural SPI master responder.
module tb_spi_frame_seq;

  localparam int CLK_DIV = 6;
  localparam int GAP_T   = 4;
  localparam int TMO     = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [7:0]  cmd_i = 8'h00;
  logic        busy_o;
  logic [15:0] data_o;
  logic        done_o;
  logic        err_o;
  logic        ena_2clk_o;
  logic        start_o;
  logic        ack_o;
  logic [7:0]  tx_o;
  logic        busy_i = 1'b0;
  logic [7:0]  rx_i = 8'h00;
  logic        ssb_o;

  always #5 clk = ~clk;

  spi_frame_seq #(
    .CLK_DIV(CLK_DIV), .ADDR(8'h08), .SETUP_TICKS(2), .GAP_TICKS(GAP_T), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .cmd_i(cmd_i), .busy_o(busy_o),
    .data_o(data_o), .done_o(done_o), .err_o(err_o), .ena_2clk_o(ena_2clk_o),
    .start_o(start_o), .ack_o(ack_o), .tx_o(tx_o), .busy_i(busy_i), .rx_i(rx_i),
    .ssb_o(ssb_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // behavioural master: responds to start_o, returns rx_tbl bytes in order
  logic       master_en = 1'b0;
  int         m_st = 0, m_cnt = 0, rx_idx = 0;
  int         ssb_viol = 0, tx_chg = 0;
  logic [7:0] rx_tbl [32];
  logic [7:0] tx_log [$];

  always @(negedge clk) begin
    if (!rst) begin
      m_st   = 0;
      busy_i = 1'b0;
    end else if (master_en) begin
      if (m_st != 0 && ssb_o) ssb_viol++;
      case (m_st)
        0: if (start_o) begin
          if (ssb_o) ssb_viol++;
          tx_log.push_back(tx_o);
          m_cnt = 0;
          m_st  = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == 2) begin busy_i = 1'b1; m_cnt = 0; m_st = 2; end
        end
        2: begin
          if (tx_o !== tx_log[$]) tx_chg++;
          m_cnt++;
          if (m_cnt == 8) begin
            rx_i   = rx_tbl[rx_idx];
            rx_idx++;
            busy_i = 1'b0;
            m_st   = 3;
          end
        end
        default: if (ack_o) m_st = 0;
      endcase
    end
  end

  int done_cnt = 0, ack_cnt = 0, hi_run = 0;
  int gap_log [$];

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (ack_o) ack_cnt++;
    if (ssb_o) hi_run++;
    else begin
      if (hi_run > 0) gap_log.push_back(hi_run);
      hi_run = 0;
    end
  end

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 5000) begin tick(1); n++; end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o !== 1'b0 && n < 5000) begin tick(1); n++; end
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  int n, base_done, base_ack, tbase, gbase;

  initial begin
    rx_tbl[0] = 8'h11; rx_tbl[1] = 8'h22; rx_tbl[2] = 8'h33; rx_tbl[3] = 8'h44;
    for (int i = 4; i < 32; i++) rx_tbl[i] = 8'(i) + 8'h60;

    // reset state
    tick(3);
    chk("rst_ssb", {31'd0, ssb_o}, 32'd1);
    chk("rst_outs", {busy_o, done_o, err_o, ena_2clk_o, start_o, ack_o}, 32'd0);
    chk("rst_data", {16'd0, data_o}, 32'd0);
    chk("rst_tx", {24'd0, tx_o}, 32'd0);

    // divider: release counts as cycle 1, pulse in cycle CLK_DIV, then every CLK_DIV
    rst = 1'b1;
    n = 1;
    while (!ena_2clk_o && n < 50) begin tick(1); n++; end
    chk("ena_first", 32'(n), 32'(CLK_DIV));
    tick(1);
    chk("ena_width", {31'd0, ena_2clk_o}, 32'd0);
    n = 1;
    while (!ena_2clk_o && n < 50) begin tick(1); n++; end
    chk("ena_period", 32'(n), 32'(CLK_DIV));

    // single frame
    master_en = 1'b1;
    cmd_i = 8'hA5; req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    chk("f1_busy", {31'd0, busy_o}, 32'd1);
    chk("f1_ssb", {31'd0, ssb_o}, 32'd0);
    wait_done(1, "f1_done_wait");
    chk("f1_data", {16'd0, data_o}, 32'h0000_3344);
    chk("f1_tx", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h08A5_0000);
    chk("f1_ssb_low", 32'(ssb_viol), 32'd0);
    chk("f1_tx_stable", 32'(tx_chg), 32'd0);
    chk("f1_err", {31'd0, err_o}, 32'd0);
    wait_idle("f1_idle");
    chk("f1_done_cnt", 32'(done_cnt), 32'd1);

    // timeout: master silent
    master_en = 1'b0;
    base_ack = ack_cnt;
    cmd_i = 8'h3C; req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    n = 0;
    while (!start_o && n < 200) begin tick(1); n++; end
    chk("to_start_seen", {31'd0, start_o}, 32'd1);
    n = 0;
    while (!err_o && n < TMO + 10) begin tick(1); n++; end
    chk("to_latency", 32'(n), 32'(TMO + 1));
    chk("to_ssb", {31'd0, ssb_o}, 32'd1);
    chk("to_data", {16'd0, data_o}, 32'h0000_3344);
    chk("to_ack_once", 32'(ack_cnt - base_ack), 32'd1);
    wait_idle("to_idle");
    chk("to_no_done", 32'(done_cnt), 32'd1);
    chk("to_err_sticky", {31'd0, err_o}, 32'd1);

    // req held high for three frames, cmd changed per frame
    master_en = 1'b1;
    base_done = done_cnt;
    tbase = tx_log.size();
    gbase = gap_log.size();
    cmd_i = 8'hC1; req_i = 1'b1;
    tick(1);
    chk("bb_err_clr", {31'd0, err_o}, 32'd0);
    cmd_i = 8'hC2;
    wait_done(base_done + 1, "bb_done1");
    n = 0;
    while (ssb_o && n < 500) begin tick(1); n++; end
    chk("bb_f2_start", {31'd0, ssb_o}, 32'd0);
    cmd_i = 8'hC3;
    wait_done(base_done + 2, "bb_done2");
    n = 0;
    while (ssb_o && n < 500) begin tick(1); n++; end
    chk("bb_f3_start", {31'd0, ssb_o}, 32'd0);
    req_i = 1'b0;
    wait_done(base_done + 3, "bb_done3");
    wait_idle("bb_idle");
    chk("bb_done_cnt", 32'(done_cnt - base_done), 32'd3);
    chk("bb_cmds", {8'h00, tx_log[tbase+1], tx_log[tbase+5], tx_log[tbase+9]}, 32'h00C1_C2C3);
    chk("bb_gap12", 32'(gap_log[gbase+1] >= GAP_T * CLK_DIV), 32'd1);
    chk("bb_gap23", 32'(gap_log[gbase+2] >= GAP_T * CLK_DIV), 32'd1);
    chk("bb_data", {16'd0, data_o}, 32'h0000_6E6F);

    // async reset during byte 2
    tbase = tx_log.size();
    cmd_i = 8'h5A; req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    n = 0;
    while (!(tx_log.size() == tbase + 3 && m_st == 2) && n < 500) begin tick(1); n++; end
    chk("rs_in_byte2", 32'(tx_log.size() - tbase), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("rs_ssb", {31'd0, ssb_o}, 32'd1);
    chk("rs_busy", {31'd0, busy_o}, 32'd0);
    chk("rs_data", {16'd0, data_o}, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);
    base_done = done_cnt;
    tbase = tx_log.size();
    cmd_i = 8'h96; req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    wait_done(base_done + 1, "rs_done_wait");
    chk("rs_data2", {16'd0, data_o}, 32'h0000_7475);
    chk("rs_tx", {tx_log[tbase], tx_log[tbase+1], tx_log[tbase+2], tx_log[tbase+3]}, 32'h0896_0000);
    wait_idle("rs_idle");

    // req pulse during an active frame is ignored
    base_done = done_cnt;
    tbase = tx_log.size();
    cmd_i = 8'h77; req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    n = 0;
    while (tx_log.size() < tbase + 2 && n < 500) begin tick(1); n++; end
    cmd_i = 8'h88; req_i = 1'b1;
    tick(1);
    req_i = 1'b0;
    wait_done(base_done + 1, "ig_done_wait");
    wait_idle("ig_idle");
    tick(60);
    chk("ig_done_cnt", 32'(done_cnt - base_done), 32'd1);
    chk("ig_frames", 32'(tx_log.size() - tbase), 32'd4);
    chk("ig_cmd", {24'd0, tx_log[tbase+1]}, 32'h0000_0077);
    chk("ig_data", {16'd0, data_o}, 32'h0000_7879);
    chk("all_ssb_low", 32'(ssb_viol), 32'd0);
    chk("all_tx_stable", 32'(tx_chg), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_frame_seq.md
Name: spi_frame_seq

Overview:
- Sequencer directly upstream of the SPI master.
- Generates the master's 2×SCK clock enable and drives its start/ack/tx handshake byte by byte.
- Frames each multi-byte transfer with slave select and captures the response bytes into a parallel result.
- Replaces ad-hoc LED controllers; sits between the application logic and the SPI master.

Parameters:
- CLK_DIV, 6: clk cycles per ena_2clk_o pulse; legal range 2..255.
- ADDR, 8'h08: value sent as frame byte 0.
- SETUP_TICKS, 2: ena ticks between ssb falling and the first start_o.
- GAP_TICKS, 4: ena ticks with ssb high after a frame before the next may begin.
- TIMEOUT, 1023: clk cycles allowed per handshake wait before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- req_i  in  1  frame request (level or pulse); sampled only in IDLE
- cmd_i  in  8  command byte, latched when a frame is accepted
- busy_o  out  1  high from frame acceptance until return to IDLE
- data_o  out  16  {rx byte2, rx byte3}, updated at frame end
- done_o  out  1  one-clk pulse on successful frame completion
- err_o  out  1  sticky timeout flag; cleared on next accepted req_i
- ena_2clk_o  out  1  one-clk enable pulse every CLK_DIV clks
- start_o  out  1  to master start_i
- ack_o  out  1  to master ack_i
- tx_o  out  8  to master tx_i
- busy_i  in  1  from master busy_o
- rx_i  in  8  from master received byte; valid when busy_i falls
- ssb_o  out  1  slave select, active-low

Behaviour:
- Reset (rst=0, async): all outputs 0 except ssb_o=1. data_o=0, err_o=0, state IDLE, divider count 0.
- Divider:
  - Free-running 8-bit counter 0..CLK_DIV-1.
  - ena_2clk_o=1 for exactly one clk when count==CLK_DIV-1.
  - Runs in every state after reset.
- Frame: 4 bytes, tx sequence ADDR, cmd latched, 8'h00, 8'h00. Bytes 0/1 rx are discarded; bytes 2/3 rx are kept.
- FSM states and transitions:
  - IDLE: req_i=1 → latch cmd, busy_o=1, clear err_o, byte index=0, ssb_o=0 → SETUP.
  - SETUP: count SETUP_TICKS ena pulses → START.
  - START:
    - start_o=1, tx_o=current byte.
    - On busy_i=1: start_o=0 → XFER.
  - XFER: on busy_i falling (registered edge detect) → ACK.
  - ACK:
    - ack_o=1 for one clk; capture rx_i into the byte slot.
    - If index<3: index+1 → START.
    - Else → GAP with ssb_o=1, data_o updated, done_o pulsed.
  - GAP: count GAP_TICKS ena pulses → IDLE, busy_o=0.
- tx_o is stable from START entry until ACK; it never changes while busy_i=1.
- Timeout:
  - Watchdog counter resets on every state entry.
  - In START or XFER, reaching TIMEOUT clks triggers abort: start_o=0, ack_o pulsed once, ssb_o=1, err_o=1, data_o unchanged, no done_o → GAP.
- req_i outside IDLE is ignored; frames are not queued.
- req_i held high yields back-to-back frames separated by the GAP only.
- busy_i high on IDLE exit is tolerated. START waits for a fresh rise: busy_i must be low for ≥1 clk before it counts.
- Async reset mid-frame:
  - ssb_o goes high immediately; outputs return to reset values.
  - No partial data_o update.

Test Plan:
- Reset then req_i pulse, cmd_i=8'hA5, behavioural master returning 11,22,33,44 → tx sequence 08,A5,00,00; data_o=16'h3344; one done_o pulse; ssb_o low for the whole frame.
- CLK_DIV=6 → ena_2clk_o high 1 clk in every 6; first pulse 6 clks after reset release.
- Master never asserts busy_i → err_o=1 at TIMEOUT+1 clks after START entry; ssb_o=1; data_o keeps its previous value; no done_o.
- req_i held high for 3 frames → three done_o pulses, each pair ≥GAP_TICKS×CLK_DIV clks of ssb_o high between frames; cmd_i re-latched per frame.
- rst asserted during byte 2 → ssb_o=1 and busy_o=0 within the same cycle (async); data_o=0; next req_i runs a clean full frame.
- req_i pulsed during an active frame → ignored; exactly one done_o.
